uart_tx: RTL
============

# uart_tx

UART serial transmitter; the transmit-side counterpart to the UART receiver in the UART block. It accepts a parallel byte with a one-cycle valid strobe and serializes it onto TX_OUT as a standard frame: start bit, data LSB first, optional parity bit, stop bit. CLK is the TX bit clock, so each frame bit lasts exactly one CLK cycle. A busy flag tells the upstream producer, the system controller or FIFO reader, when a new byte may be offered.

## Interface
- DATA_WIDTH, 8, width of the parallel data word.
- CLK  input  1  TX bit clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data to transmit; sampled only on acceptance.
- Data_Valid  input  1  strobe requesting transmission of P_DATA.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
- TX_OUT  output  1  serial line; idle high. Registered.
- Busy  output  1  high while a frame is in progress. Registered.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE: TX_OUT=1, Busy=0.
  - On a rising edge with Data_Valid=1, latch P_DATA, PAR_EN and PAR_TYP into internal registers and go to START.
- START: TX_OUT=0, Busy=1. Next state is DATA.
- DATA: TX_OUT = latched_data[bit_cnt], LSB first.
  - bit_cnt counts 0..DATA_WIDTH-1 and clears on entry to DATA.
  - After bit DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY: TX_OUT = ^latched_data XOR latched PAR_TYP. Even parity gives XOR of the data bits; odd parity gives its inverse. Next state is STOP.
- STOP: TX_OUT=1, Busy=1. Next state is IDLE.
- Data_Valid is ignored in every state except IDLE; no request is queued.
- Changes on P_DATA, PAR_EN and PAR_TYP after acceptance have no effect on the frame in flight.
- Parity is computed from the latched data only. It may be precomputed at acceptance or computed combinationally from the latched register.
- bit_cnt width is $clog2(DATA_WIDTH) bits and must not wrap before the last data bit.

## Timing
- Reset (RST=0, asynchronous) forces:
  - TX_OUT=1 and Busy=0 immediately;
  - FSM to IDLE;
  - bit_cnt and latched registers to 0.
- Reset mid-frame aborts the frame. The line returns high at once, and no partial frame resumes after RST deasserts.
- First rising edge after RST deasserts: normal IDLE sampling.
- Acceptance edge E, with Data_Valid=1 in IDLE:
  - Edges E through E+DATA_WIDTH+1 (or E+DATA_WIDTH+2 with parity): TX_OUT shows the start bit, data bits, optional parity bit, then the stop bit, one bit per cycle, with Busy=1 throughout.
  - Edge E+DATA_WIDTH+2 (E+DATA_WIDTH+3 with parity): TX_OUT=1, Busy=0.
- Frame length with Busy=1: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity. This is 10 or 11 cycles for 8 bits.
- Back-to-back frames: Data_Valid held high during STOP is not accepted. The next acceptance is the first edge where Busy=0, giving a minimum of one idle-high cycle between frames.
- Data_Valid asserted on the same edge that leaves STOP for IDLE is ignored.
- Latency from the acceptance edge to the start bit on TX_OUT is 0 cycles. TX_OUT changes at the acceptance edge itself.

## Test plan
- Reset: hold RST=0 with random inputs, including Data_Valid=1. Require TX_OUT=1 and Busy=0 throughout. After release with Data_Valid=0 for 5 cycles, the outputs stay unchanged.
- No parity: P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid. Require TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1, Busy=1 for exactly those 10 cycles, then TX_OUT=1 and Busy=0.
- Parity:
  - P_DATA=0xA5 (four ones), PAR_EN=1, PAR_TYP=0: parity bit 0, 11-bit frame, stop bit 1.
  - Repeat with PAR_TYP=1: parity bit 1.
  - P_DATA=0x07, even parity: parity bit 1.
- Input isolation: start a frame with 0x3C. Mid-frame, change P_DATA to 0xFF, toggle PAR_EN and PAR_TYP, and pulse Data_Valid. Require the serialized data to equal 0x3C, the original frame length to hold, and no second frame to start.
- Back-to-back: hold Data_Valid=1 continuously with 0x55 then 0x0F. Require two complete frames separated by exactly one idle-high cycle, with the second frame carrying 0x0F.
- Reset mid-frame: assert RST during data bit 3 of 0x81. Require TX_OUT=1 and Busy=0 at once. After release, a new 0x81 request produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-side and serial-side signals of the UART transmitter.
//   P_DATA     - parallel byte offered by the producer
//   Data_Valid - one-cycle request strobe
//   PAR_EN     - insert a parity bit in this frame
//   PAR_TYP    - 0 = even parity, 1 = odd parity
//   TX_OUT     - serial line, idle high
//   Busy       - frame in progress; a new byte is only taken while low
// master: the producer (controller / FIFO reader). slave: the transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter. CLK is the bit clock, so each frame bit
// (start, DATA_WIDTH data bits LSB first, optional parity, stop) lasts one cycle.
// Ports:
//   CLK - bit clock, rising edge
//   RST - asynchronous, active-low reset (line forced idle high, Busy low)
//   bus - uart_tx_if.slave: P_DATA/Data_Valid/PAR_EN/PAR_TYP in, TX_OUT/Busy out
// TX_OUT and Busy are registered. They are decoded from the next state so the
// start bit appears at the acceptance edge itself (zero latency).
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  uart_tx_if.slave   bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_next_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  accept_s;
  logic                  tx_next_s;
  logic                  busy_next_s;
  logic                  tx_out_r;
  logic                  busy_r;

  // Parity of the data word; odd=1 inverts the even-parity result.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic odd);
    return (^d) ^ odd;
  endfunction

  // State, bit counter and frame-parameter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        data_r    <= bus.P_DATA;
        par_en_r  <= bus.PAR_EN;
        par_typ_r <= bus.PAR_TYP;
      end
    end
  end

  // Next-state and bit-counter logic; requests outside IDLE are dropped.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Data_Valid) begin
          state_next_s = START;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        state_next_s = DATA;
        cnt_next_s   = {CNT_W{1'b0}};
      end
      DATA: begin
        if (cnt_r == LAST_CNT) begin
          state_next_s = par_en_r ? PARITY : STOP;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      PARITY: begin
        state_next_s = STOP;
      end
      STOP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode from the state being entered, so outputs register in step.
  always_comb begin
    tx_next_s   = 1'b1;
    busy_next_s = 1'b1;
    case (state_next_s)
      IDLE: begin
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
      end
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = data_r[cnt_next_s];
      PARITY:  tx_next_s = parity_bit(data_r, par_typ_r);
      STOP:    tx_next_s = 1'b1;
      default: begin
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Registered serial line and busy flag; reset drives the line idle at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_out_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_out_r <= tx_next_s;
      busy_r   <= busy_next_s;
    end
  end

  assign bus.TX_OUT = tx_out_r;
  assign bus.Busy   = busy_r;

endmodule
